// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board writer and its helpers.
package tetris_pkg;

    localparam int ROWS     = 22;
    localparam int COLS     = 10;
    localparam int VIS_ROWS = 20;

    // Row 0 is the top of the playfield; column c maps to bit c of a row.
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct packed {
        logic [4:0] row;
        logic [3:0] col;
    } cell_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } board_state_t;

    // Saturating increment for the cleared-line counter.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

endpackage

// File: rtl/piece_mask.sv
// Maps four tetromino cells onto a board-sized bit mask, dropping any cell
// outside the visible playfield.
module piece_mask
    import tetris_pkg::*;
(
    input  logic         valid_i,
    input  cell_t [3:0]  cells_i,
    output board_t       mask_o
);

    // Compare every playfield position against the four cells; reserved rows stay 0.
    always_comb begin
        mask_o = '0;
        for (int r = 0; r < VIS_ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int i = 0; i < 4; i++) begin
                    mask_o[r][c] = mask_o[r][c] |
                                   (valid_i &&
                                    (cells_i[i].row == 5'(r)) &&
                                    (cells_i[i].col == 4'(c)));
                end
            end
        end
    end

endmodule

// File: rtl/tetris_board_writer.sv
// Stored Tetris playfield: locks pieces, clears full rows, and publishes the
// board with the falling piece overlaid for the grid renderer.
module tetris_board_writer
    import tetris_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_valid,
    output logic             lock_ready,
    input  logic [3:0][4:0]  lock_row,
    input  logic [3:0][3:0]  lock_col,
    input  logic             active_valid,
    input  logic [3:0][4:0]  active_row,
    input  logic [3:0][3:0]  active_col,
    input  logic             clear_board,
    output board_t           display_array,
    output logic             done,
    output logic [2:0]       lines_cleared,
    output logic             game_over
);

    board_state_t state_q, state_d;
    board_t       board_q, board_d;
    board_t       display_q, display_d;
    cell_t [3:0]  lock_cells_q, lock_cells_d;
    logic [4:0]   ptr_q, ptr_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [2:0]   lines_q, lines_d;
    logic         done_q, done_d;
    logic         game_over_q, game_over_d;

    cell_t [3:0]  active_cells_s;
    board_t       lock_mask_s;
    board_t       active_mask_s;
    logic [COLS-1:0] landed_row_s;

    // Pack the falling-piece coordinates into cells for the overlay mask.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            active_cells_s[i] = {active_row[i], active_col[i]};
        end
    end

    piece_mask u_lock_mask (
        .valid_i (1'b1),
        .cells_i (lock_cells_q),
        .mask_o  (lock_mask_s)
    );

    piece_mask u_active_mask (
        .valid_i (active_valid),
        .cells_i (active_cells_s),
        .mask_o  (active_mask_s)
    );

    // A clear request in IDLE takes priority, so the lock is refused that cycle.
    assign lock_ready    = (state_q == IDLE) && !clear_board;
    assign display_array = display_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign game_over     = game_over_q;

    // Row that lands at the scan pointer when a shift happens.
    always_comb begin
        if (ptr_q != 5'd0) begin
            landed_row_s = board_q[ptr_q - 5'd1];
        end else begin
            landed_row_s = '0;
        end
    end

    // Next-state logic for the lock / scan / shift sequencer.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        lock_cells_d = lock_cells_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        lines_d      = lines_q;
        done_d       = 1'b0;
        game_over_d  = game_over_q;

        case (state_q)
            IDLE: begin
                if (clear_board) begin
                    board_d     = '0;
                    game_over_d = 1'b0;
                end else if (lock_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        lock_cells_d[i] = {lock_row[i], lock_col[i]};
                    end
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                if (|(board_q & lock_mask_s)) begin
                    game_over_d = 1'b1;
                end else begin
                    game_over_d = game_over_q;
                end
                board_d = board_q | lock_mask_s;
                ptr_d   = 5'(VIS_ROWS - 1);
                cnt_d   = 3'd0;
                state_d = SCAN;
            end

            SCAN: begin
                if (&board_q[ptr_q]) begin
                    state_d = SHIFT;
                end else if (ptr_q == 5'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    lines_d = cnt_q;
                end else begin
                    ptr_d = ptr_q - 5'd1;
                end
            end

            // The shift also judges the row that lands at the pointer, so a
            // re-check costs no extra cycle.
            SHIFT: begin
                for (int r = 1; r < VIS_ROWS; r++) begin
                    if (5'(r) <= ptr_q) begin
                        board_d[r] = board_q[r-1];
                    end else begin
                        board_d[r] = board_q[r];
                    end
                end
                board_d[0] = '0;
                cnt_d      = sat_inc3(cnt_q);
                if ((ptr_q != 5'd0) && (&landed_row_s)) begin
                    state_d = SHIFT;
                end else if (ptr_q == 5'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    lines_d = cnt_d;
                end else begin
                    ptr_d   = ptr_q - 5'd1;
                    state_d = SCAN;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Renderer view: stored board OR falling piece, reserved rows forced low.
    always_comb begin
        display_d     = board_q | active_mask_s;
        display_d[20] = '0;
        display_d[21] = '0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            board_q      <= '0;
            display_q    <= '0;
            lock_cells_q <= '0;
            ptr_q        <= 5'd0;
            cnt_q        <= 3'd0;
            lines_q      <= 3'd0;
            done_q       <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            display_q    <= display_d;
            lock_cells_q <= lock_cells_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            lines_q      <= lines_d;
            done_q       <= done_d;
            game_over_q  <= game_over_d;
        end
    end

endmodule

// File: doc/tetris_board_writer.md
Name: tetris_board_writer

Overview:
- Owns the stored playfield and produces the `display_array` that the grid renderer reads.
- Accepts "lock piece" commands from game control, ORs the four tetromino cells into the board, then clears full rows with a row-by-row scan and shift.
- Overlays the currently falling piece onto the stored board, so the renderer always sees board plus active piece.
- Sits between game-control FSM and the VGA grid renderer.

Parameters:
- ROWS, 22, rows in display_array; rows 0-19 are the playfield (row 0 at top), rows 20-21 are reserved and always 0.
- COLS, 10, columns per row.
- VIS_ROWS, 20, rows scanned for line clears.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lock_valid  in  1  lock request
- lock_ready  out  1  high only in IDLE
- lock_row  in  4x5  row of each of the 4 cells to lock
- lock_col  in  4x4  column of each of the 4 cells to lock
- active_valid  in  1  enables the active-piece overlay
- active_row  in  4x5  rows of the falling piece
- active_col  in  4x4  columns of the falling piece
- clear_board  in  1  wipes the board; honoured only in IDLE
- display_array  out  22x10  registered board OR overlay, to the renderer
- done  out  1  one-cycle pulse when lock and clear processing finishes
- lines_cleared  out  3  rows cleared by the last lock; valid when done=1, held until the next done
- game_over  out  1  sticky; set on a lock onto an occupied cell

Behaviour:
- Reset state: board all 0, state IDLE, `display_array`=0, `done`=0, `lines_cleared`=0, `game_over`=0, `lock_ready`=1 on the cycle after reset deasserts.
- Reset asserted mid-operation aborts any WRITE, SCAN or SHIFT immediately. No partial results survive.
- Handshake: a lock transfers on a cycle where `lock_valid` && `lock_ready`. Coordinates are sampled in that cycle only. `lock_valid` while busy is ignored; the sender must hold it.
- FSM: IDLE -> WRITE -> SCAN <-> SHIFT -> DONE -> IDLE.
  - IDLE: wait for a lock transfer or `clear_board`. If both are high, `clear_board` wins and the lock is not accepted (`lock_ready` drops for 1 cycle while the board clears).
  - WRITE (1 cycle): set the board bit at each in-range cell (row<20, col<10). Out-of-range cells are ignored. If any in-range cell is already 1, set `game_over`; the write still occurs. Duplicate coordinates are harmless. Scan pointer r=19, clear counter=0.
  - SCAN (1 cycle per row): if row r is all ones, go to SHIFT. Otherwise, if r==0 go to DONE, else r<=r-1 and stay in SCAN.
  - SHIFT (1 cycle): rows 1..r take the previous contents of rows 0..r-1, row 0 becomes 0, counter+1, return to SCAN with r unchanged so the shifted-down row is re-checked.
  - DONE (1 cycle): `done`=1, `lines_cleared`=counter, next state IDLE.
- Latency: with the accept cycle as 0, WRITE is cycle 1, SCAN/SHIFT occupies cycles 2..21+k for k cleared rows, and `done` is asserted in cycle 22+k.
- `lines_cleared` saturates at 7 (max 4 with legal tetrominoes).
- Overlay: `display_array` is registered each cycle as board | mask. The mask has a bit set for each in-range active cell when `active_valid`=1, else is 0. Latency is 1 cycle from board or active inputs.
- The overlay is applied in every state, so the renderer sees intermediate shifts. This is acceptable.
- Rows 20-21 of `display_array` are forced to 0.
- `game_over` clears only on `rst` or `clear_board`.

Decomposition:
- Shared package `tetris_pkg` holds:
  - constants ROWS, COLS, VIS_ROWS;
  - typedef `board_t` (logic [21:0][9:0]);
  - typedef `cell_t` (struct: row 5b, col 4b);
  - enum `board_state_t` {IDLE, WRITE, SCAN, SHIFT, DONE}.
- One natural sub-module: `piece_mask`, a combinational mapping of 4 `cell_t` plus valid to a `board_t` mask with range checks. It is used twice: by the WRITE path and by the overlay.

Test Plan:
- Reset, then lock cells (19,0)(19,1)(19,2)(19,3) -> `done` at cycle 22 after accept, `lines_cleared`=0, `display_array`[19]=10'b0000001111.
- Pre-fill row 19 cols 0-5, lock (19,6)(19,7)(19,8)(19,9) -> `done` at cycle 23, `lines_cleared`=1, row 19=0, rows 0-18 shifted down.
- Fill rows 16-19 except col 9, lock an I-piece vertical at col 9 rows 16-19 -> `lines_cleared`=4, `done` at cycle 26, board all zero.
- Lock onto an occupied cell (10,5) -> `game_over`=1 and stays 1 across later locks. `clear_board` in IDLE -> `game_over`=0 and board 0.
- `active_valid`=1 with cells (0,4)(0,5)(1,4)(1,5) on an empty board -> next cycle `display_array`[0]=`display_array`[1]=10'b0000110000. An out-of-range cell (21,3) -> no bit set.
- Assert `rst` during SHIFT -> the next cycle has an all-zero board, `lock_ready`=1, `done` is never pulsed, and a new lock is processed normally.
